// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: 8-bit register selects, 16-bit pair selects,
// IDU modes, writeback sources, flag layout and pair-to-byte helpers.
package cpu_pkg;

  typedef enum logic [3:0] {
    R8_MEM = 4'd0,
    R8_A   = 4'd1,
    R8_F   = 4'd2,
    R8_B   = 4'd3,
    R8_C   = 4'd4,
    R8_D   = 4'd5,
    R8_E   = 4'd6,
    R8_H   = 4'd7,
    R8_L   = 4'd8,
    R8_W   = 4'd9,
    R8_Z   = 4'd10,
    R8_SPH = 4'd11,
    R8_SPL = 4'd12,
    R8_PCH = 4'd13,
    R8_PCL = 4'd15
  } reg8_t;

  localparam logic [3:0] R8_NONE = 4'd14;

  typedef enum logic [2:0] {
    R16_WZ       = 3'd0,
    R16_BC       = 3'd1,
    R16_DE       = 3'd2,
    R16_HL       = 3'd3,
    R16_AF       = 3'd4,
    R16_SP       = 3'd5,
    R16_PC       = 3'd6,
    R16_PCH_ZERO = 3'd7
  } reg16_t;

  typedef enum logic [1:0] {
    IDU_INC = 2'd0,
    IDU_DEC = 2'd1,
    IDU_ADJ = 2'd2
  } idu_mode_t;

  typedef enum logic [1:0] {
    RR_WB_NONE = 2'd0,
    RR_WB_IDU  = 2'd1,
    RR_WB_WZ   = 2'd2
  } s_rr_wb_t;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  // PCH_ZERO pairs PCH with the always-zero MEM slot for the low byte.
  function automatic logic [3:0] pair_hi(input logic [2:0] sel);
    logic [3:0] r;
    case (sel)
      R16_WZ:  r = R8_W;
      R16_BC:  r = R8_B;
      R16_DE:  r = R8_D;
      R16_HL:  r = R8_H;
      R16_AF:  r = R8_A;
      R16_SP:  r = R8_SPH;
      default: r = R8_PCH;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] pair_lo(input logic [2:0] sel);
    logic [3:0] r;
    case (sel)
      R16_WZ:  r = R8_Z;
      R16_BC:  r = R8_C;
      R16_DE:  r = R8_E;
      R16_HL:  r = R8_L;
      R16_AF:  r = R8_F;
      R16_SP:  r = R8_SPL;
      R16_PC:  r = R8_PCL;
      default: r = R8_MEM;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_idu.sv
// Incrementer/decrementer: INC, DEC and the JR high-byte adjust (ADJ).
module cpu_idu
  import cpu_pkg::*;
(
  input  logic [15:0] ab,
  input  logic [1:0]  idu,
  input  logic        adj_carry,
  input  logic        adj_sign,
  output logic [15:0] idu_out
);

  logic [7:0] adj_hi;

  // ADJ fixes up PCH after the low-byte add done by the ALU; mode 3 acts as INC.
  always_comb begin
    if (adj_carry && !adj_sign) begin
      adj_hi = ab[15:8] + 8'd1;
    end else if (!adj_carry && adj_sign) begin
      adj_hi = ab[15:8] - 8'd1;
    end else begin
      adj_hi = ab[15:8];
    end
    case (idu)
      IDU_DEC: idu_out = ab - 16'd1;
      IDU_ADJ: idu_out = {adj_hi, ab[7:0]};
      default: idu_out = ab + 16'd1;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with IDU; REG_FILE_DEBUG_EN adds a side-effect
// free pair read port (dbg_sel/dbg_rr).
module reg_file
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  s_ab,
  input  logic [3:0]  s_db,
  input  logic [3:0]  t_db,
  input  logic [7:0]  db_wr,
  input  logic [1:0]  idu,
  input  logic [1:0]  s_rr_wb,
  input  logic [2:0]  t_rr_wb,
  input  logic        wr_pc,
  input  logic        adj_carry,
  input  logic        adj_sign,
  input  logic        f_we,
  input  logic [3:0]  f_in,
`ifdef REG_FILE_DEBUG_EN
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_rr,
`endif
  output logic [15:0] ab,
  output logic [7:0]  db_rd,
  output logic [15:0] idu_out,
  output logic [3:0]  flags
);

  logic [7:0]  rf [16];
  logic [7:0]  rf_nxt [16];
  logic        wb_en;
  logic [15:0] wb_val;

  function automatic logic [7:0] rd8(input logic [3:0] sel, input logic [7:0] v);
    return ((sel == R8_MEM) || (sel == R8_NONE)) ? 8'h00 : v;
  endfunction

  assign ab    = {rd8(pair_hi(s_ab), rf[pair_hi(s_ab)]), rd8(pair_lo(s_ab), rf[pair_lo(s_ab)])};
  assign db_rd = rd8(s_db, rf[s_db]);
  assign flags = rf[R8_F][7:4];

`ifdef REG_FILE_DEBUG_EN
  assign dbg_rr = (dbg_sel == R16_PCH_ZERO) ? 16'h0000 :
                  {rf[pair_hi(dbg_sel)], rf[pair_lo(dbg_sel)]};
`endif

  cpu_idu u_idu (
    .ab        (ab),
    .idu       (idu),
    .adj_carry (adj_carry),
    .adj_sign  (adj_sign),
    .idu_out   (idu_out)
  );

  assign wb_en  = ((s_rr_wb == RR_WB_IDU) || (s_rr_wb == RR_WB_WZ)) && (t_rr_wb != R16_PCH_ZERO);
  assign wb_val = (s_rr_wb == RR_WB_IDU) ? idu_out : {rf[R8_W], rf[R8_Z]};

  // Writes applied lowest priority first so later ones win on a shared byte.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      rf_nxt[i] = rf[i];
    end
    if (f_we) begin
      rf_nxt[R8_F] = {f_in, 4'h0};
    end else begin
      rf_nxt[R8_F] = rf[R8_F];
    end
    if (t_db != R8_MEM) begin
      rf_nxt[t_db] = db_wr;
    end else begin
      rf_nxt[R8_MEM] = 8'h00;
    end
    if (wb_en) begin
      rf_nxt[pair_hi(t_rr_wb)] = wb_val[15:8];
      // JR step 1: ADJ into WZ only lands in W so Z can take the displacement.
      if (!((idu == IDU_ADJ) && (t_rr_wb == R16_WZ))) begin
        rf_nxt[pair_lo(t_rr_wb)] = wb_val[7:0];
      end else begin
        rf_nxt[R8_W] = wb_val[15:8];
      end
    end else begin
      rf_nxt[R8_MEM] = 8'h00;
    end
    if (wr_pc) begin
      rf_nxt[R8_PCH] = idu_out[15:8];
      rf_nxt[R8_PCL] = idu_out[7:0];
    end else begin
      rf_nxt[R8_MEM] = 8'h00;
    end
    rf_nxt[R8_F][3:0] = 4'h0;
    rf_nxt[R8_MEM]    = 8'h00;
    rf_nxt[R8_NONE]   = 8'h00;
  end

  // Register state; reset clears everything except SP and PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        rf[i] <= 8'h00;
      end
      rf[R8_SPH] <= RESET_SP[15:8];
      rf[R8_SPL] <= RESET_SP[7:0];
      rf[R8_PCH] <= RESET_PC[15:8];
      rf[R8_PCL] <= RESET_PC[7:0];
    end else begin
      for (int i = 0; i < 16; i++) begin
        rf[i] <= rf_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random stimulus
// against a byte-array reference model.
module tb_reg_file;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  s_ab;
  logic [3:0]  s_db;
  logic [3:0]  t_db;
  logic [7:0]  db_wr;
  logic [1:0]  idu;
  logic [1:0]  s_rr_wb;
  logic [2:0]  t_rr_wb;
  logic        wr_pc;
  logic        adj_carry;
  logic        adj_sign;
  logic        f_we;
  logic [3:0]  f_in;
  logic [15:0] ab;
  logic [7:0]  db_rd;
  logic [15:0] idu_out;
  logic [3:0]  flags;
`ifdef REG_FILE_DEBUG_EN
  logic [15:0] dbg_rr;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] m [16];

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst), .s_ab(s_ab), .s_db(s_db), .t_db(t_db), .db_wr(db_wr),
    .idu(idu), .s_rr_wb(s_rr_wb), .t_rr_wb(t_rr_wb), .wr_pc(wr_pc),
    .adj_carry(adj_carry), .adj_sign(adj_sign), .f_we(f_we), .f_in(f_in),
`ifdef REG_FILE_DEBUG_EN
    .dbg_sel(s_ab), .dbg_rr(dbg_rr),
`endif
    .ab(ab), .db_rd(db_rd), .idu_out(idu_out), .flags(flags)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: register names to byte slots, pairs by name.
  function automatic logic [3:0] hi_of(input logic [2:0] p);
    logic [3:0] t [8] = '{R8_W, R8_B, R8_D, R8_H, R8_A, R8_SPH, R8_PCH, R8_PCH};
    return t[p];
  endfunction

  function automatic logic [3:0] lo_of(input logic [2:0] p);
    logic [3:0] t [8] = '{R8_Z, R8_C, R8_E, R8_L, R8_F, R8_SPL, R8_PCL, R8_MEM};
    return t[p];
  endfunction

  function automatic logic [7:0] m_rd(input logic [3:0] sel);
    return ((sel == 4'd0) || (sel == 4'd14)) ? 8'h00 : m[sel];
  endfunction

  function automatic logic [15:0] m_pair(input logic [2:0] p);
    if (p == 3'd7) return {m[R8_PCH], 8'h00};
    return {m_rd(hi_of(p)), m_rd(lo_of(p))};
  endfunction

  function automatic logic [15:0] m_idu(input logic [15:0] a, input logic [1:0] mode,
                                        input logic ac, input logic as);
    int v;
    int hi;
    if (mode == 2'd1) begin
      v = (int'(a) + 65535) % 65536;
      return v[15:0];
    end
    if (mode == 2'd2) begin
      hi = int'(a[15:8]);
      if (ac && !as) hi = hi + 1;
      if (!ac && as) hi = hi + 255;
      hi = hi % 256;
      return {hi[7:0], a[7:0]};
    end
    v = (int'(a) + 1) % 65536;
    return v[15:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    m[R8_SPH] = 8'hFF;
    m[R8_SPL] = 8'hFE;
  endtask

  task automatic idle();
    s_ab = 3'd0; s_db = 4'd0; t_db = 4'd0; db_wr = 8'h00; idu = 2'd0;
    s_rr_wb = 2'd0; t_rr_wb = 3'd0; wr_pc = 1'b0; adj_carry = 1'b0;
    adj_sign = 1'b0; f_we = 1'b0; f_in = 4'h0;
  endtask

  // Called at posedge+1 with inputs driven; checks outputs, commits the model.
  task automatic cycle();
    logic [7:0]  n [16];
    logic [15:0] iv;
    logic [15:0] wv;
    #2;
    iv = m_idu(m_pair(s_ab), idu, adj_carry, adj_sign);
    check("ab", ab, m_pair(s_ab));
    check("db_rd", {8'h00, db_rd}, {8'h00, m_rd(s_db)});
    check("idu_out", idu_out, iv);
    check("flags", {12'h000, flags}, {12'h000, m[R8_F][7:4]});
`ifdef REG_FILE_DEBUG_EN
    check("dbg_rr", dbg_rr, (s_ab == 3'd7) ? 16'h0000 : m_pair(s_ab));
`endif
    n = m;
    if (f_we) n[R8_F] = {f_in, 4'h0};
    if (t_db != 4'd0 && t_db != 4'd14) n[t_db] = db_wr;
    if ((s_rr_wb == 2'd1 || s_rr_wb == 2'd2) && t_rr_wb != 3'd7) begin
      wv = (s_rr_wb == 2'd1) ? iv : {m[R8_W], m[R8_Z]};
      n[hi_of(t_rr_wb)] = wv[15:8];
      if (!(idu == 2'd2 && t_rr_wb == 3'd0)) n[lo_of(t_rr_wb)] = wv[7:0];
    end
    if (wr_pc) begin
      n[R8_PCH] = iv[15:8];
      n[R8_PCL] = iv[7:0];
    end
    n[R8_F][3:0] = 4'h0;
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_flags", {12'h000, flags}, 16'h0000);
    s_ab = R16_SP;
    #1;
    check("rst_sp", ab, 16'hFFFE);
    s_ab = R16_PC;
    #1;
    check("rst_pc", ab, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      s_db = 4'(i);
      #1;
      check("rst_r8", {8'h00, db_rd}, (i == 11) ? 16'h00FF : ((i == 12) ? 16'h00FE : 16'h0000));
    end
    model_reset();
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr8(input logic [3:0] r, input logic [7:0] v);
    idle(); t_db = r; db_wr = v; cycle();
  endtask

  task automatic peek8(input string tag, input logic [3:0] r, input logic [7:0] exp);
    idle(); s_db = r;
    #1;
    check(tag, {8'h00, db_rd}, {8'h00, exp});
    cycle();
  endtask

  task automatic peek16(input string tag, input logic [2:0] p, input logic [15:0] exp);
    idle(); s_ab = p;
    #1;
    check(tag, ab, exp);
    cycle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    wr8(R8_A, 8'h99);
    do_reset();

    // Reads see the pre-edge value, then the new one.
    wr8(R8_B, 8'h11);
    idle(); t_db = R8_B; db_wr = 8'h7E; s_db = R8_B;
    #1;
    check("rd_old", {8'h00, db_rd}, 16'h0011);
    cycle();
    peek8("rd_new", R8_B, 8'h7E);
    wr8(R8_F, 8'hFF);
    peek8("f_mask", R8_F, 8'hF0);
    wr8(R8_NONE, 8'hAB);
    peek8("sel14", R8_NONE, 8'h00);

    wr8(R8_SPH, 8'h00); wr8(R8_SPL, 8'h00);
    idle(); s_ab = R16_SP; idu = IDU_DEC; s_rr_wb = RR_WB_IDU; t_rr_wb = R16_SP; cycle();
    peek16("sp_wrap", R16_SP, 16'hFFFF);
    wr8(R8_PCH, 8'hFF); wr8(R8_PCL, 8'hFF);
    idle(); s_ab = R16_PC; idu = IDU_INC; wr_pc = 1'b1; cycle();
    peek16("pc_wrap", R16_PC, 16'h0000);

    // JR: adjust PCH into W while Z takes the displacement.
    wr8(R8_PCH, 8'h12); wr8(R8_PCL, 8'hF0);
    idle(); s_ab = R16_PCH_ZERO; idu = IDU_ADJ; adj_carry = 1'b1; s_rr_wb = RR_WB_IDU;
    t_rr_wb = R16_WZ; t_db = R8_Z; db_wr = 8'h05; cycle();
    peek8("jr_w", R8_W, 8'h13);
    peek8("jr_z", R8_Z, 8'h05);
    idle(); s_ab = R16_WZ; idu = IDU_INC; wr_pc = 1'b1; cycle();
    peek16("jr_pc", R16_PC, 16'h1306);
    wr8(R8_PCH, 8'h12);
    idle(); s_ab = R16_PCH_ZERO; idu = IDU_ADJ; adj_sign = 1'b1; s_rr_wb = RR_WB_IDU;
    t_rr_wb = R16_WZ; cycle();
    peek8("jr_w_neg", R8_W, 8'h11);

    wr8(R8_W, 8'h12); wr8(R8_Z, 8'h34);
    idle(); t_db = R8_L; db_wr = 8'hAA; s_rr_wb = RR_WB_WZ; t_rr_wb = R16_HL; cycle();
    peek16("wb_over_8", R16_HL, 16'h1234);
    idle(); s_ab = R16_HL; idu = IDU_INC; wr_pc = 1'b1; t_db = R8_PCL; db_wr = 8'h55; cycle();
    peek16("pc_over_8", R16_PC, 16'h1235);

    wr8(R8_W, 8'h55); wr8(R8_Z, 8'hFF);
    idle(); s_rr_wb = RR_WB_WZ; t_rr_wb = R16_AF; cycle();
    peek8("pop_a", R8_A, 8'h55);
    peek8("pop_f", R8_F, 8'hF0);
    check("pop_flags", {12'h000, flags}, 16'h000F);
    idle(); f_we = 1'b1; f_in = 4'b1010; cycle();
    peek8("f_we", R8_F, 8'hA0);
    idle(); f_we = 1'b1; f_in = 4'hF; t_db = R8_F; db_wr = 8'h3C; cycle();
    peek8("f8_over_we", R8_F, 8'h30);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        s_ab = 3'($urandom); s_db = 4'($urandom); t_db = 4'($urandom);
        db_wr = 8'($urandom); idu = 2'($urandom); s_rr_wb = 2'($urandom);
        t_rr_wb = 3'($urandom); wr_pc = ($urandom_range(0, 3) == 0);
        adj_carry = 1'($urandom); adj_sign = 1'($urandom);
        f_we = 1'($urandom); f_in = 4'($urandom);
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
Architectural register file and incrementer/decrementer unit (IDU). It sits directly downstream of the opcode decoder and consumes its per-step control outputs: s_ab, s_db, t_db, idu, s_rr_wb, t_rr_wb and wr_pc. It holds A, F, B, C, D, E, H, L, SP, PC and the temporaries W/Z. Each cycle it drives the address bus and the register-sourced data byte, and it commits 8-bit writes, 16-bit writebacks and PC updates on the clock edge.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
RESET_SP, 16'hFFFE, SP value loaded on reset

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset; asynchronous, active-high
s_ab  in  3  reg16_t select for the address bus
s_db  in  4  reg8_t read select
t_db  in  4  reg8_t write select; MEM (0) = no register write
db_wr  in  8  byte written to t_db (ALU result or memory data, muxed externally)
idu  in  2  idu_mode_t: INC, DEC or ADJ
s_rr_wb  in  2  s_rr_wb_t: 16-bit writeback source
t_rr_wb  in  3  reg16_t: 16-bit writeback target
wr_pc  in  1  latch PC from IDU output
adj_carry  in  1  ALU carry out from the PCL+Z add (ADJ mode only)
adj_sign  in  1  bit 7 of the displacement Z (ADJ mode only)
f_we  in  1  flag write enable
f_in  in  4  {z,n,h,c} flag value
ab  out  16  address bus
db_rd  out  8  value of register s_db
idu_out  out  16  IDU result
flags  out  4  F[7:4] as {z,n,h,c}

Behaviour:
- Reset (asynchronous): A, F, B, C, D, E, H, L, W, Z = 0; SP = RESET_SP; PC = RESET_PC. Reset asserted mid-instruction discards all pending writes.
- ab is combinational from s_ab:
  - WZ, BC, DE, HL, AF, SP, PC map to the register pairs.
  - PCH_ZERO = {PCH, 8'h00}.
- db_rd is combinational.
  - Reads return the pre-edge value; there is no write-through bypass.
  - s_db = MEM or 4'b1110 returns 8'h00.
  - s_db = F returns {F[7:4], 4'b0000}.
- IDU (combinational):
  - INC: ab+1. DEC: ab-1. Both are modulo 2^16; FFFF+1 = 0000 and 0000-1 = FFFF.
  - ADJ: high byte = ab[15:8] + {+1 if adj_carry & !adj_sign; -1 (8'hFF) if !adj_carry & adj_sign; else 0}, modulo 256. Low byte = ab[7:0].
  - Encoding 2'b11 behaves as INC.
- Commit on posedge, all simultaneous and independent unless a priority rule below applies:
  1. 8-bit write: if t_db != MEM, reg[t_db] <= db_wr. t_db = F stores {db_wr[7:4], 4'b0}.
  2. 16-bit writeback:
     - RR_WB_IDU: pair[t_rr_wb] <= idu_out.
     - RR_WB_WZ: pair[t_rr_wb] <= {W, Z}.
     - RR_WB_NONE: no write.
     - Target AF forces F[3:0] = 0.
     - Target PCH_ZERO is ignored.
  3. wr_pc: PC <= idu_out.
  4. f_we: F[7:4] <= f_in.
- Priority on the same byte:
  - wr_pc beats 16-bit writeback and 8-bit write on PCH/PCL.
  - 16-bit writeback beats 8-bit write.
  - Exception: when idu = ADJ and t_rr_wb = WZ, the writeback updates W only, so a Z write from t_db lands (JR step 1).
  - An 8-bit write to F beats f_we.
- Latency: every write is visible on db_rd and ab one cycle after the edge. The block has no stall or handshake; it commits every cycle.

Optional Feature:
REG_FILE_DEBUG_EN:
- Defined: adds input dbg_sel [2:0] (reg16_t) and output dbg_rr [15:0], a combinational read of the selected pair with no side effects. dbg_sel = PCH_ZERO returns 16'h0000.
- Undefined: neither port exists and there is no logic for them.

Decomposition:
- Package cpu_pkg holds reg8_t, reg16_t, idu_mode_t, s_rr_wb_t and flags_t. The decoder imports the same package.
- One sub-module: cpu_idu, the combinational INC/DEC/ADJ adder (ab, idu, adj_carry, adj_sign -> idu_out).
- All state lives in reg_file.

Test Plan:
- Reset: rst=1 mid-cycle -> all registers 0, SP=FFFE, PC=0000 immediately, without a clock edge. flags=0.
- INC/DEC wrap:
  - s_ab=SP, idu=DEC, RR_WB_IDU, t_rr_wb=SP with SP=0000 -> SP=FFFF next cycle.
  - s_ab=PC, idu=INC, wr_pc with PC=FFFF -> PC=0000.
- JR sequence:
  - PC=12F0, s_ab=PCH_ZERO, idu=ADJ, adj_carry=1, adj_sign=0, RR_WB_IDU to WZ, t_db=Z, db_wr=05 -> W=13, Z=05.
  - adj_carry=0, adj_sign=1 -> W=11.
  - Then s_ab=WZ, INC, wr_pc -> PC=1306.
- Conflict: t_db=L, db_wr=AA with RR_WB_WZ to HL, W=12, Z=34 -> HL=1234. Separately, t_db=PCL with wr_pc -> PC=idu_out.
- F masking:
  - POP AF: RR_WB_WZ to AF, W=55, Z=FF -> A=55, F=F0, flags=F.
  - f_we=1, f_in=4'b1010 -> F=A0.
- Read-old-value: t_db=B, db_wr=7E and s_db=B in the same cycle -> db_rd shows the old B. The next cycle shows 7E.
